lt_uint_bitserial_ctrl: RTL and testbench

Sequencer for unsigned less-than on a one-bit-per-cycle datapath, suited to PIM-style bit-serial evaluation.
- Accepts an operand pair (A, B) over a valid/ready handshake.
- Steps a single 1-bit borrow-compare cell LSB-first for WIDTH cycles.
- Returns Y = (A < B) over a valid/ready handshake.
- Sits between a requester (host/scheduler) and the bit-serial compute array; replaces a WIDTH-bit parallel comparator when area dominates latency.

---
 rtl/lt_uint_bitserial_ctrl_pkg.sv | 16 +
 rtl/lt_uint_bitserial_ctrl_bitcell.sv | 12 +
 rtl/lt_uint_bitserial_ctrl.sv | 102 ++++++++++
 tb/tb_lt_uint_bitserial_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lt_uint_bitserial_ctrl_pkg.sv
// Shared types and constants for the bit-serial unsigned less-than sequencer.
package lt_uint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bit LT_SERIAL_LSB_FIRST = 1'b1;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lt_uint_bitserial_ctrl_bitcell.sv
// One-bit borrow-compare cell; this is the primitive the compute array evaluates each step.
module lt_serial_bitcell (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic borrow_out
);

    // Borrow out of (a - b - borrow_in): set when b wins, or ties propagate the old borrow.
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/lt_uint_bitserial_ctrl.sv
// Sequencer for unsigned A < B evaluated one bit per cycle, LSB first.
//   state | meaning
//   IDLE  | waiting for an operand pair, in_ready=1
//   RUN   | stepping the borrow cell over WIDTH bits, busy=1
//   DONE  | result held on Y with out_valid=1 until out_ready
module lt_uint_bitserial_ctrl
    import lt_uint_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Y,
    output logic             busy
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             borrow_nxt;
    logic             y_q;
    logic             bit_a;
    logic             bit_b;

    assign bit_a = LT_SERIAL_LSB_FIRST ? sa[0] : sa[WIDTH-1];
    assign bit_b = LT_SERIAL_LSB_FIRST ? sb[0] : sb[WIDTH-1];

    lt_serial_bitcell u_cell (
        .a         (bit_a),
        .b         (bit_b),
        .borrow_in (borrow),
        .borrow_out(borrow_nxt)
    );

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign Y         = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            y_q    <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa     <= A;
                        sb     <= B;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    borrow <= borrow_nxt;
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        y_q   <= borrow_nxt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Consumer handshake frees the slot; a waiting pair is taken in the same edge.
                    if (out_ready) begin
                        if (in_valid) begin
                            sa     <= A;
                            sb     <= B;
                            borrow <= 1'b0;
                            cnt    <= '0;
                            state  <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lt_uint_bitserial_ctrl.sv
// Self-checking bench: WIDTH=8 instance with scoreboard monitor, plus a WIDTH=1 instance.
module tb_lt_uint_bitserial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid, out_ready;
    logic [7:0] a, b;
    logic       in_ready, out_valid, y, busy;

    logic       flush1, in_valid1, out_ready1;
    logic [0:0] a1, b1;
    logic       in_ready1, out_valid1, y1, busy1;

    always #5 clk = ~clk;

    lt_uint_bitserial_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Y(y), .busy(busy)
    );

    lt_uint_bitserial_ctrl #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1), .Y(y1), .busy(busy1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic y;
        int   acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_pop;
    logic ov_prev  = 1'b0;
    int   busy_cnt = 0;
    logic last_y   = 1'b0;
    int   n_out    = 0;
    int   out_cyc[$];
    logic y_hist[$];

    // Scoreboard: expected result pushed on each accepted pair, popped on each result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            ov_prev  = 1'b0;
            busy_cnt = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
                check("in_ready_low_in_run", in_ready, 1'b0);
            end
            if (out_valid && !ov_prev) begin
                check("out_valid_has_op", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    check("latency", cyc - sb_q[0].acc, 9);
                    check("busy_cycles", busy_cnt, 8);
                end
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
                e_pop = sb_q.pop_front();
                check("y_vs_model", y, e_pop.y);
                last_y = y;
                y_hist.push_back(y);
                out_cyc.push_back(cyc);
                n_out++;
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(exp_t'{y: (a < b), acc: cyc});
                busy_cnt = 0;
            end
            ov_prev = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n0, input string name);
        for (int i = 0; i < 40 && n_out == n0; i++) tick();
        check(name, n_out != n0, 1'b1);
    endtask

    task automatic run_one(input logic [7:0] va, input logic [7:0] vb, output logic yo);
        int n0;
        n0        = n_out;
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(n0, "result_timeout");
        yo = last_y;
    endtask

    task automatic run_w1(input logic va, input logic vb, input logic exp_y, input string name);
        int lat;
        a1         = va;
        b1         = vb;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({name, "_busy"}, busy1, 1'b1);
            if (out_valid1) break;
        end
        check({name, "_lat"}, lat, 2);
        check({name, "_y"}, y1, exp_y);
        tick();
    endtask

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vy;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic yo;
        int   n0;

        vt[0] = '{8'h03, 8'h05, 1'b1};
        vt[1] = '{8'h05, 8'h03, 1'b0};
        vt[2] = '{8'hAA, 8'hAA, 1'b0};
        vt[3] = '{8'h00, 8'hFF, 1'b1};
        vt[4] = '{8'hFF, 8'h00, 1'b0};
        vt[5] = '{8'h7F, 8'h80, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        flush1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_w1_in_ready", in_ready1, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_one(vt[i].va, vt[i].vb, yo);
            check($sformatf("table_y_%0d", i), yo, vt[i].vy);
        end

        // Backpressure in DONE; operands changed during RUN must be ignored.
        n0 = n_out;
        a = 8'h03; b = 8'h05; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; a = 8'h09; b = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_reach_done", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_y", y, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_out(n0, "bp_release");
        tick();
        check("bp_back_idle", out_valid, 1'b0);

        // Reset mid-RUN; Y is 1 from the previous op so its clearing is visible.
        a = 8'h01; b = 8'h02; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_y", y, 1'b0);
        check("arst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_one(8'h10, 8'h20, yo);
        check("post_rst_y", yo, 1'b1);

        // Flush in RUN cycle 3 with a pair presented.
        n0 = n_out;
        a = 8'h01; b = 8'h02; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1; in_valid = 1'b1; a = 8'h00; b = 8'h55;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_busy", busy, 1'b0);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        repeat (12) tick();
        check("flush_no_output", n_out - n0, 0);
        // Flush in IDLE blocks acceptance even though in_ready is high.
        flush = 1'b1; in_valid = 1'b1; a = 8'h00; b = 8'h01;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_no_accept", busy, 1'b0);
        tick();

        // Back-to-back with in_valid and out_ready held high.
        n0 = n_out;
        out_cyc.delete();
        y_hist.delete();
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: begin a = 8'd1; b = 8'd2; end
                1: begin a = 8'd2; b = 8'd1; end
                default: begin a = 8'd9; b = 8'd9; end
            endcase
            in_valid = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            check("b2b_accept", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && n_out < n0 + 3; i++) tick();
        check("b2b_count", n_out - n0, 3);
        if (out_cyc.size() >= 3) begin
            check("b2b_space_0", out_cyc[1] - out_cyc[0], 9);
            check("b2b_space_1", out_cyc[2] - out_cyc[1], 9);
            check("b2b_y_0", y_hist[0], 1'b1);
            check("b2b_y_1", y_hist[1], 1'b0);
            check("b2b_y_2", y_hist[2], 1'b0);
        end
        tick();

        run_w1(1'b0, 1'b1, 1'b1, "w1_01");
        run_w1(1'b1, 1'b0, 1'b0, "w1_10");
        run_w1(1'b1, 1'b1, 1'b0, "w1_11");

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
